// File: rtl/zork_text_pkg.sv
`default_nettype none
// ============================================================================
// zork_text_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the text window renderer: character cell geometry,
// the RGB332 pixel type and a black constant.
// Revision: 1.0  initial release
// ============================================================================
package zork_text_pkg;

   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   localparam rgb332_t RGB_BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};

endpackage
`default_nettype wire

// File: rtl/reveal_ctrl.sv
`default_nettype none
// ============================================================================
// reveal_ctrl
// ----------------------------------------------------------------------------
// Frame-start detection, typewriter reveal counter and cursor blink.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   pix_en_i         : enable; everything holds while low
//   vsync_i          : active-low vsync, falling edge = frame start
//   new_text_i       : restarts the reveal and forces the cursor on
//   reveal_cnt_o     : number of revealed cells (0..CELLS)
//   cursor_on_o      : blink phase of the cursor block
//   reveal_done_o    : every cell revealed
// Revision: 1.0  initial release
// ============================================================================
module reveal_ctrl #(
   parameter int CELLS        = 160,
   parameter int REVEAL_STEP  = 2,
   parameter int BLINK_FRAMES = 16,
   localparam int CW          = $clog2(CELLS + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          pix_en_i,
   input  logic          vsync_i,
   input  logic          new_text_i,
   output logic [CW-1:0] reveal_cnt_o,
   output logic          cursor_on_o,
   output logic          reveal_done_o
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   // Wide enough that count + step cannot wrap before saturation.
   localparam int SW = CW + 9;
   localparam logic [SW-1:0] LIMIT      = SW'(CELLS);
   localparam logic [SW-1:0] STEP       = SW'(REVEAL_STEP);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic          vs_prev_q, vs_prev_d;
   logic [CW-1:0] reveal_cnt_q, reveal_cnt_d;
   logic [BW-1:0] frame_cnt_q, frame_cnt_d;
   logic          cursor_on_q, cursor_on_d;
   logic          w_frame_edge;
   logic [SW-1:0] w_sum;
   logic [SW-1:0] w_sat;

   assign w_frame_edge = pix_en_i & vs_prev_q & ~vsync_i;
   assign w_sum        = SW'(reveal_cnt_q) + STEP;
   assign w_sat        = (w_sum >= LIMIT) ? LIMIT : w_sum;

   always_comb begin
      vs_prev_d    = pix_en_i ? vsync_i : vs_prev_q;
      reveal_cnt_d = reveal_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      cursor_on_d  = cursor_on_q;
      // A restart outranks a frame edge landing in the same cycle.
      if (pix_en_i && new_text_i) begin
         reveal_cnt_d = '0;
         frame_cnt_d  = '0;
         cursor_on_d  = 1'b1;
      end else if (w_frame_edge) begin
         reveal_cnt_d = CW'(w_sat);
         if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            cursor_on_d = ~cursor_on_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
      // Step of zero means "show everything": pinned at full, even while idle.
      if (REVEAL_STEP == 0) begin
         reveal_cnt_d = CW'(CELLS);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vs_prev_q    <= 1'b1;
         reveal_cnt_q <= '0;
         frame_cnt_q  <= '0;
         cursor_on_q  <= 1'b1;
      end else begin
         vs_prev_q    <= vs_prev_d;
         reveal_cnt_q <= reveal_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         cursor_on_q  <= cursor_on_d;
      end
   end

   assign reveal_cnt_o  = reveal_cnt_q;
   assign cursor_on_o   = cursor_on_q;
   assign reveal_done_o = (reveal_cnt_q == CW'(CELLS));

endmodule
`default_nettype wire

// File: rtl/text_window_renderer.sv
`default_nettype none
// ============================================================================
// text_window_renderer
// ----------------------------------------------------------------------------
// Three-stage text-mode raster engine producing RGB332 pixels for a
// COLS x ROWS character window placed at (X0, Y0).
//   clk_50MHz_i, rst_async_i, pix_en_i : clock, async reset, pixel enable
//   pixel_x_i/pixel_y_i/video_on_i     : raster position from vga_control
//   hsync_i/vsync_i -> hsync_o/vsync_o : syncs, delayed 3 enabled cycles
//   text_addr_o/text_char_i            : synchronous text memory port
//   font_addr_o/font_row_i             : synchronous font memory port
//   fg_i/bg_i                          : window colours
//   new_text_i                         : restart typewriter reveal
//   r_o/g_o/b_o                        : registered pixel colour
//   reveal_done_o                      : all cells revealed
// The address outputs are combinational; the external synchronous memories
// provide the register between stages 0->1 and 1->2.
// Revision: 1.0  initial release
// ============================================================================
module text_window_renderer
   import zork_text_pkg::*;
#(
   parameter int COLS         = 80,
   parameter int ROWS         = 2,
   parameter int X0           = 0,
   parameter int Y0           = 0,
   parameter int REVEAL_STEP  = 2,
   parameter int BLINK_FRAMES = 16,
   localparam int CELLS       = COLS * ROWS,
   localparam int AW          = (CELLS > 1) ? $clog2(CELLS) : 1
) (
   input  logic          clk_50MHz_i,
   input  logic          rst_async_i,
   input  logic          pix_en_i,
   input  logic [9:0]    pixel_x_i,
   input  logic [9:0]    pixel_y_i,
   input  logic          video_on_i,
   input  logic          hsync_i,
   input  logic          vsync_i,
   input  logic          new_text_i,
   output logic [AW-1:0] text_addr_o,
   input  logic [7:0]    text_char_i,
   output logic [11:0]   font_addr_o,
   input  logic [7:0]    font_row_i,
   input  logic [7:0]    fg_i,
   input  logic [7:0]    bg_i,
   output logic [2:0]    r_o,
   output logic [2:0]    g_o,
   output logic [1:0]    b_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          reveal_done_o
);

   localparam int CW = $clog2(CELLS + 1);
   localparam logic [11:0] X_LO  = 12'(X0);
   localparam logic [11:0] X_HI  = 12'(X0 + CHAR_W * COLS);
   localparam logic [11:0] Y_LO  = 12'(Y0);
   localparam logic [11:0] Y_HI  = 12'(Y0 + CHAR_H * ROWS);
   localparam logic [9:0]  X0_10 = 10'(X0);
   localparam logic [9:0]  Y0_10 = 10'(Y0);

   // ---------------- stage 0: window test and cell address ----------------
   logic          w_in_win;
   logic [9:0]    w_x_off, w_y_off;
   logic [AW-1:0] w_cell;

   // Compare on widened values first; the offsets are only trusted in-window.
   assign w_in_win = ({2'b00, pixel_x_i} >= X_LO) && ({2'b00, pixel_x_i} < X_HI) &&
                     ({2'b00, pixel_y_i} >= Y_LO) && ({2'b00, pixel_y_i} < Y_HI);
   assign w_x_off  = pixel_x_i - X0_10;
   assign w_y_off  = pixel_y_i - Y0_10;
   assign w_cell   = AW'(int'(w_y_off[9:4]) * COLS + int'(w_x_off[9:3]));
   assign text_addr_o = w_in_win ? w_cell : '0;

   logic          s0_in_win_q, s0_video_q, s0_hs_q, s0_vs_q;
   logic [2:0]    s0_xl_q;
   logic [3:0]    s0_yl_q;
   logic [AW-1:0] s0_cell_q;

   // ---------------- stage 1: glyph row address ----------------
   assign font_addr_o = s0_in_win_q ? {text_char_i, s0_yl_q} : 12'd0;

   logic          s1_in_win_q, s1_video_q, s1_hs_q, s1_vs_q;
   logic [2:0]    s1_xl_q;
   logic [AW-1:0] s1_cell_q;

   // ---------------- stage 2: colour ----------------
   logic [CW-1:0] w_reveal_cnt;
   logic          w_cursor_on;
   logic          w_bit;
   logic [CW-1:0] w_cell_ext;
   rgb332_t       colour_q, colour_d;
   logic          s2_hs_q, s2_vs_q;

   assign w_bit      = font_row_i[~s1_xl_q];   // 7 - x, MSB is leftmost
   assign w_cell_ext = CW'(s1_cell_q);

   always_comb begin
      colour_d = RGB_BLACK;
      if (!s1_video_q || !s1_in_win_q) begin
         colour_d = RGB_BLACK;
      end else if ((w_cell_ext > w_reveal_cnt) ||
                   ((w_cell_ext == w_reveal_cnt) && !w_cursor_on)) begin
         colour_d = rgb332_t'(bg_i);
      end else if ((w_cell_ext == w_reveal_cnt) && w_cursor_on && !reveal_done_o) begin
         colour_d = rgb332_t'(fg_i);
      end else begin
         colour_d = w_bit ? rgb332_t'(fg_i) : rgb332_t'(bg_i);
      end
   end

   always_ff @(posedge clk_50MHz_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         s0_in_win_q <= 1'b0;
         s0_video_q  <= 1'b0;
         s0_hs_q     <= 1'b1;
         s0_vs_q     <= 1'b1;
         s0_xl_q     <= '0;
         s0_yl_q     <= '0;
         s0_cell_q   <= '0;
         s1_in_win_q <= 1'b0;
         s1_video_q  <= 1'b0;
         s1_hs_q     <= 1'b1;
         s1_vs_q     <= 1'b1;
         s1_xl_q     <= '0;
         s1_cell_q   <= '0;
         colour_q    <= RGB_BLACK;
         s2_hs_q     <= 1'b1;
         s2_vs_q     <= 1'b1;
      end else if (pix_en_i) begin
         s0_in_win_q <= w_in_win;
         s0_video_q  <= video_on_i;
         s0_hs_q     <= hsync_i;
         s0_vs_q     <= vsync_i;
         s0_xl_q     <= w_x_off[2:0];
         s0_yl_q     <= w_y_off[3:0];
         s0_cell_q   <= w_cell;
         s1_in_win_q <= s0_in_win_q;
         s1_video_q  <= s0_video_q;
         s1_hs_q     <= s0_hs_q;
         s1_vs_q     <= s0_vs_q;
         s1_xl_q     <= s0_xl_q;
         s1_cell_q   <= s0_cell_q;
         colour_q    <= colour_d;
         s2_hs_q     <= s1_hs_q;
         s2_vs_q     <= s1_vs_q;
      end
   end

   assign r_o     = colour_q.r;
   assign g_o     = colour_q.g;
   assign b_o     = colour_q.b;
   assign hsync_o = s2_hs_q;
   assign vsync_o = s2_vs_q;

   reveal_ctrl #(
      .CELLS        (CELLS),
      .REVEAL_STEP  (REVEAL_STEP),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_reveal (
      .clk_i         (clk_50MHz_i),
      .rst_i         (rst_async_i),
      .pix_en_i      (pix_en_i),
      .vsync_i       (vsync_i),
      .new_text_i    (new_text_i),
      .reveal_cnt_o  (w_reveal_cnt),
      .cursor_on_o   (w_cursor_on),
      .reveal_done_o (reveal_done_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_text_window_renderer.sv
`default_nettype none
// ============================================================================
// tb_text_window_renderer
// ----------------------------------------------------------------------------
// Directed bench. dut_a: X0=0, Y0=0, REVEAL_STEP=2 (reveal and blink).
// dut_b: X0=8, Y0=16, REVEAL_STEP=0 (latency and window edges).
// Text memory holds 'A' in every cell; glyph 'A' row0 = FF, row1 = 80.
// Revision: 1.0  initial release
// ============================================================================
module tb_text_window_renderer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, pix_en, video_on, hsync, vsync, new_text;
   logic [9:0] px, py;
   logic [7:0] fg, bg;

   logic [7:0]  text_addr_a, text_addr_b;
   logic [7:0]  char_a = 8'h00, char_b = 8'h00;
   logic [11:0] font_addr_a, font_addr_b;
   logic [7:0]  font_row_a = 8'h00, font_row_b = 8'h00;
   logic [2:0]  r_a, g_a, r_b, g_b;
   logic [1:0]  b_a, b_b;
   logic        hs_a, vs_a, hs_b, vs_b, done_a, done_b;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] FG = 8'hE3;
   localparam logic [7:0] BG = 8'h1C;

   text_window_renderer #(.COLS(80), .ROWS(2), .X0(0), .Y0(0),
                          .REVEAL_STEP(2), .BLINK_FRAMES(16)) dut_a (
      .clk_50MHz_i(clk), .rst_async_i(rst), .pix_en_i(pix_en),
      .pixel_x_i(px), .pixel_y_i(py), .video_on_i(video_on),
      .hsync_i(hsync), .vsync_i(vsync), .new_text_i(new_text),
      .text_addr_o(text_addr_a), .text_char_i(char_a),
      .font_addr_o(font_addr_a), .font_row_i(font_row_a),
      .fg_i(fg), .bg_i(bg), .r_o(r_a), .g_o(g_a), .b_o(b_a),
      .hsync_o(hs_a), .vsync_o(vs_a), .reveal_done_o(done_a));

   text_window_renderer #(.COLS(80), .ROWS(2), .X0(8), .Y0(16),
                          .REVEAL_STEP(0), .BLINK_FRAMES(16)) dut_b (
      .clk_50MHz_i(clk), .rst_async_i(rst), .pix_en_i(pix_en),
      .pixel_x_i(px), .pixel_y_i(py), .video_on_i(video_on),
      .hsync_i(hsync), .vsync_i(vsync), .new_text_i(new_text),
      .text_addr_o(text_addr_b), .text_char_i(char_b),
      .font_addr_o(font_addr_b), .font_row_i(font_row_b),
      .fg_i(fg), .bg_i(bg), .r_o(r_b), .g_o(g_b), .b_o(b_b),
      .hsync_o(hs_b), .vsync_o(vs_b), .reveal_done_o(done_b));

   function automatic logic [7:0] font(input logic [11:0] a);
      if (a[11:4] != 8'h41) return 8'h00;
      case (a[3:0])
         4'd0:    return 8'hFF;
         4'd1:    return 8'h80;
         default: return 8'h00;
      endcase
   endfunction

   // Synchronous memories, advancing only on enabled cycles.
   always @(posedge clk) begin
      if (pix_en) begin
         char_a     <= (text_addr_a < 8'd160) ? 8'h41 : 8'h00;
         char_b     <= (text_addr_b < 8'd160) ? 8'h41 : 8'h00;
         font_row_a <= font(font_addr_a);
         font_row_b <= font(font_addr_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic show(input int x, input int y);
      px = 10'(x);
      py = 10'(y);
      repeat (3) tick();
   endtask

   task automatic frame_edge();
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1; pix_en = 1'b1; video_on = 1'b1; hsync = 1'b1; vsync = 1'b1;
      new_text = 1'b0; px = 10'd0; py = 10'd0; fg = FG; bg = BG;
      repeat (3) tick();

      // Reset state
      check("rst_rgb_a",   {24'd0, r_a, g_a, b_a}, 32'd0);
      check("rst_hs_a",    {31'd0, hs_a}, 32'd1);
      check("rst_vs_a",    {31'd0, vs_a}, 32'd1);
      check("rst_taddr_a", {24'd0, text_addr_a}, 32'd0);
      check("rst_faddr_a", {20'd0, font_addr_a}, 32'd0);
      check("rst_done_a",  {31'd0, done_a}, 32'd0);
      check("rst_done_b",  {31'd0, done_b}, 32'd0);

      rst = 1'b0;
      tick();
      check("done_b_step0", {31'd0, done_b}, 32'd1);
      check("done_a_post",  {31'd0, done_a}, 32'd0);

      // Exact 3-cycle latency on dut_b for pixel (8,16), with hsync marker
      show(700, 0);
      check("lat_idle_b", {24'd0, r_b, g_b, b_b}, 32'd0);
      px = 10'd8; py = 10'd16; hsync = 1'b0;
      tick();
      check("taddr_b_00",  {24'd0, text_addr_b}, 32'd0);
      check("taddr_a_81",  {24'd0, text_addr_a}, 32'd81);
      check("faddr_b_A0",  {20'd0, font_addr_b}, 32'h410);
      px = 10'd700; py = 10'd0; hsync = 1'b1;
      tick();
      check("lat_t2_rgb",  {24'd0, r_b, g_b, b_b}, 32'd0);
      check("lat_t2_hs",   {31'd0, hs_b}, 32'd1);
      tick();
      check("lat_t3_rgb",  {24'd0, r_b, g_b, b_b}, {24'd0, FG});
      check("lat_t3_hs",   {31'd0, hs_b}, 32'd0);
      tick();
      check("lat_t4_rgb",  {24'd0, r_b, g_b, b_b}, 32'd0);
      check("lat_t4_hs",   {31'd0, hs_b}, 32'd1);

      // Window edges on dut_b
      show(7, 16);  check("b_left_out",  {24'd0, r_b, g_b, b_b}, 32'd0);
      show(8, 15);  check("b_top_out",   {24'd0, r_b, g_b, b_b}, 32'd0);
      show(8, 17);  check("b_row1_bit7", {24'd0, r_b, g_b, b_b}, {24'd0, FG});
      show(9, 17);  check("b_row1_bit6", {24'd0, r_b, g_b, b_b}, {24'd0, BG});

      // Reveal on dut_a: restart then 3 frame edges -> 6 cells
      new_text = 1'b1; tick(); new_text = 1'b0; tick();
      repeat (3) frame_edge();
      check("cnt_6", {24'd0, dut_a.u_reveal.reveal_cnt_q}, 32'd6);
      show(40, 0);  check("cell5_row0",  {24'd0, r_a, g_a, b_a}, {24'd0, FG});
      check("taddr_a_5", {24'd0, text_addr_a}, 32'd5);
      show(41, 1);  check("cell5_r1_b6", {24'd0, r_a, g_a, b_a}, {24'd0, BG});
      show(40, 1);  check("cell5_r1_b7", {24'd0, r_a, g_a, b_a}, {24'd0, FG});
      show(48, 5);  check("cell6_cursor",{24'd0, r_a, g_a, b_a}, {24'd0, FG});
      show(56, 0);  check("cell7_hidden",{24'd0, r_a, g_a, b_a}, {24'd0, BG});
      show(48, 16); check("cell86_hid",  {24'd0, r_a, g_a, b_a}, {24'd0, BG});
      check("taddr_a_86", {24'd0, text_addr_a}, 32'd86);
      show(640, 0); check("x640_out",    {24'd0, r_a, g_a, b_a}, 32'd0);
      check("taddr_a_out", {24'd0, text_addr_a}, 32'd0);
      video_on = 1'b0;
      show(40, 0);  check("video_off",   {24'd0, r_a, g_a, b_a}, 32'd0);
      video_on = 1'b1;

      // 16 edges since restart -> cursor blinked off, count 32
      repeat (13) frame_edge();
      check("cnt_32", {24'd0, dut_a.u_reveal.reveal_cnt_q}, 32'd32);
      show(256, 0); check("cursor_off",  {24'd0, r_a, g_a, b_a}, {24'd0, BG});
      show(248, 0); check("cell31_glyph",{24'd0, r_a, g_a, b_a}, {24'd0, FG});

      // Enable low for 5 cycles: outputs and counters frozen
      pix_en = 1'b0; px = 10'd640; vsync = 1'b0;
      repeat (5) tick();
      check("frz_rgb", {24'd0, r_a, g_a, b_a}, {24'd0, FG});
      check("frz_vs",  {31'd0, vs_a}, 32'd1);
      check("frz_cnt", {24'd0, dut_a.u_reveal.reveal_cnt_q}, 32'd32);
      vsync = 1'b1; pix_en = 1'b1;
      show(640, 0); check("unfrz_rgb", {24'd0, r_a, g_a, b_a}, 32'd0);
      check("unfrz_cnt", {24'd0, dut_a.u_reveal.reveal_cnt_q}, 32'd32);

      // Saturation
      repeat (70) frame_edge();
      check("cnt_sat",  {24'd0, dut_a.u_reveal.reveal_cnt_q}, 32'd160);
      check("done_sat", {31'd0, done_a}, 32'd1);
      show(632, 16); check("cell159_r0", {24'd0, r_a, g_a, b_a}, {24'd0, FG});
      show(633, 17); check("cell159_r1", {24'd0, r_a, g_a, b_a}, {24'd0, BG});

      // Restart coincident with a frame edge: clear wins
      new_text = 1'b1; vsync = 1'b0; tick();
      new_text = 1'b0; vsync = 1'b1; tick();
      check("coinc_cnt",    {24'd0, dut_a.u_reveal.reveal_cnt_q}, 32'd0);
      check("coinc_done",   {31'd0, done_a}, 32'd0);
      check("coinc_cursor", {31'd0, dut_a.u_reveal.cursor_on_q}, 32'd1);
      check("coinc_frame",  {28'd0, dut_a.u_reveal.frame_cnt_q}, 32'd0);
      show(0, 5); check("coinc_cell0", {24'd0, r_a, g_a, b_a}, {24'd0, FG});
      show(8, 5); check("coinc_cell1", {24'd0, r_a, g_a, b_a}, {24'd0, BG});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
